// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction fetch stage and its
// fetch-to-decode bus packet.
package fetch_stage_pkg;

    localparam int ADDR_W = 32;
    localparam int INSN_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC   = '0;
    localparam logic [ADDR_W-1:0] DEFAULT_INSN_BYTES = ADDR_W'(4);

    typedef logic bool;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } FetchToDecodeBusPacket;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        SEND,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset, redirect and sequential advance, with
// redirect taking priority over advance.
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] INSN_BYTES = DEFAULT_INSN_BYTES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + INSN_BYTES;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, a one-entry hold
// register, and {pc, insn} packets sent to decode when the bus is free.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] INSN_BYTES = DEFAULT_INSN_BYTES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req_valid,
    output logic [ADDR_W-1:0]     imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INSN_W-1:0]     imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc,
    input  logic                  f2d_is_busy,
    output logic                  f2d_send,
    output FetchToDecodeBusPacket f2d_data
);

    fetch_state_t          state;
    FetchToDecodeBusPacket hold;
    FetchToDecodeBusPacket data_q;
    logic                  send_q;
    logic [ADDR_W-1:0]     pc;

    bool req_fire;
    bool send_fire;

    assign req_fire  = (state == REQ) && imem_req_ready;
    assign send_fire = (state == SEND) && !f2d_is_busy && !redirect_valid;

    fetch_pc_reg #(
        .RESET_PC   (RESET_PC),
        .INSN_BYTES (INSN_BYTES)
    ) u_pc_reg (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (send_fire),
        .pc             (pc)
    );

    // NOTE: the hold register is a handful of flops, not a memory, so it is
    // reset like any other control state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= REQ;
            hold   <= '0;
            data_q <= '0;
            send_q <= 1'b0;
        end else begin
            send_q <= send_fire;
            if (send_fire) begin
                data_q <= hold;
            end

            unique case (state)
                REQ: begin
                    if (req_fire) begin
                        state <= redirect_valid ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        // A response arriving with the redirect closes the
                        // transaction; otherwise it is still in flight.
                        state <= imem_resp_valid ? REQ : DRAIN;
                    end else if (imem_resp_valid) begin
                        hold  <= '{pc: pc, insn: imem_resp_data};
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (redirect_valid || !f2d_is_busy) begin
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_resp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted so nothing leaks out
    // in the reset cycle itself.
    assign imem_req_valid = reset_n && (state == REQ);
    assign imem_req_addr  = pc;
    assign f2d_send       = reset_n && send_q;
    assign f2d_data       = reset_n ? data_q : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, bus
// back-pressure, redirects in each state, PC wrap and mid-transaction reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Main instance (RESET_PC = 0)
    logic                  rst_n = 1'b0;
    logic                  ready = 1'b1;
    logic                  resp_v;
    logic [INSN_W-1:0]     resp_d;
    logic                  rv    = 1'b0;
    logic [ADDR_W-1:0]     rpc   = '0;
    logic                  busy  = 1'b0;
    logic                  req_v;
    logic [ADDR_W-1:0]     req_a;
    logic                  send;
    FetchToDecodeBusPacket data;

    // Wrap instance (RESET_PC = 0xFFFFFFFC)
    logic                  ready1 = 1'b1;
    logic                  resp_v1 = 1'b0;
    logic [INSN_W-1:0]     resp_d1 = 32'hDEAD_0000;
    logic                  rv1 = 1'b0;
    logic [ADDR_W-1:0]     rpc1 = '0;
    logic                  busy1 = 1'b0;
    logic                  req_v1;
    logic [ADDR_W-1:0]     req_a1;
    logic                  send1;
    FetchToDecodeBusPacket data1;

    fetch_stage dut (
        .clk             (clk),
        .reset_n         (rst_n),
        .imem_req_valid  (req_v),
        .imem_req_addr   (req_a),
        .imem_req_ready  (ready),
        .imem_resp_valid (resp_v),
        .imem_resp_data  (resp_d),
        .redirect_valid  (rv),
        .redirect_pc     (rpc),
        .f2d_is_busy     (busy),
        .f2d_send        (send),
        .f2d_data        (data)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk             (clk),
        .reset_n         (rst_n),
        .imem_req_valid  (req_v1),
        .imem_req_addr   (req_a1),
        .imem_req_ready  (ready1),
        .imem_resp_valid (resp_v1),
        .imem_resp_data  (resp_d1),
        .redirect_valid  (rv1),
        .redirect_pc     (rpc1),
        .f2d_is_busy     (busy1),
        .f2d_send        (send1),
        .f2d_data        (data1)
    );

    // Memory for the main instance: answers an accepted request after
    // 'lat' cycles with 0x1000_0000 + address; ignores the DUT's reset.
    int          lat   = 1;
    logic        pend  = 1'b0;
    int          cnt   = 0;
    logic [31:0] paddr = '0;

    assign resp_v = pend && (cnt == 1);
    assign resp_d = 32'h1000_0000 + paddr;

    always @(posedge clk) begin
        if (req_v && ready) begin
            pend  <= 1'b1;
            cnt   <= lat;
            paddr <= req_a;
        end else if (pend) begin
            if (cnt == 1) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    // Memory for the wrap instance: always ready, answers one cycle later.
    always @(posedge clk) resp_v1 <= req_v1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step until a send strobe (bounded), then check packet and spacing.
    task automatic wait_send(input string tag, input logic [31:0] pc, input int gap);
        int n = 0;
        do begin
            step();
            n++;
        end while (send !== 1'b1 && n < 30);
        check({tag, " strobe"}, 64'(send), 64'd1);
        check({tag, " packet"}, 64'(data), {pc, 32'h1000_0000 + pc});
        if (gap > 0) check({tag, " gap"}, 64'(n), 64'(gap));
    endtask

    initial begin
        // Reset cycle: outputs forced low
        #1;
        check("rst req_valid", 64'(req_v), 64'd0);
        check("rst send", 64'(send), 64'd0);
        check("rst data", 64'(data), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("first req_valid", 64'(req_v), 64'd1);
        check("first req_addr", 64'(req_a), 64'd0);
        check("wrap first addr", 64'(req_a1), 64'hFFFF_FFFC);

        // Sequential fetch, decode always free: one send every 3 cycles
        wait_send("seq0", 32'h0, 3);
        check("wrap send", 64'(send1), 64'd1);
        check("wrap packet", 64'(data1), {32'hFFFF_FFFC, 32'hDEAD_0000});
        check("wrap second addr", 64'(req_a1), 64'd0);
        wait_send("seq4", 32'h4, 3);
        wait_send("seq8", 32'h8, 3);
        wait_send("seq12", 32'hC, 3);

        // Bus busy for 10 cycles: no request, no send, data held
        busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("busy req_valid", 64'(req_v), 64'd0);
            check("busy send", 64'(send), 64'd0);
        end
        check("busy data held", 64'(data), {32'hC, 32'h1000_000C});
        busy = 1'b0;
        wait_send("after busy", 32'h10, 1);

        // Redirect in WAIT, response 3 cycles late: drained and dropped
        lat = 3;
        step();
        check("wait req_valid", 64'(req_v), 64'd0);
        rv  = 1'b1;
        rpc = 32'h100;
        step();
        rv  = 1'b0;
        lat = 1;
        check("drain req_valid", 64'(req_v), 64'd0);
        check("drain addr", 64'(req_a), 64'h100);
        step();
        check("drain resp cycle", 64'(req_v), 64'd0);
        step();
        check("post drain req_valid", 64'(req_v), 64'd1);
        check("post drain addr", 64'(req_a), 64'h100);
        wait_send("redir wait", 32'h100, 3);

        // Redirect in the same cycle as the WAIT response
        step();
        rv  = 1'b1;
        rpc = 32'h200;
        step();
        rv  = 1'b0;
        check("wait+resp req_valid", 64'(req_v), 64'd1);
        check("wait+resp addr", 64'(req_a), 64'h200);
        check("wait+resp send", 64'(send), 64'd0);
        wait_send("redir resp", 32'h200, 3);

        // Redirect in SEND with the bus free: old packet not sent
        step();
        step();
        check("send state req_valid", 64'(req_v), 64'd0);
        rv  = 1'b1;
        rpc = 32'h200;
        step();
        rv  = 1'b0;
        check("redir send strobe", 64'(send), 64'd0);
        check("redir send req_valid", 64'(req_v), 64'd1);
        check("redir send addr", 64'(req_a), 64'h200);
        wait_send("redir send", 32'h200, 3);

        // Redirect in REQ while memory stalls: valid stays, address moves
        ready = 1'b0;
        step();
        check("stall req_valid", 64'(req_v), 64'd1);
        check("stall addr", 64'(req_a), 64'h204);
        rv  = 1'b1;
        rpc = 32'h300;
        step();
        rv    = 1'b0;
        ready = 1'b1;
        check("redir req valid", 64'(req_v), 64'd1);
        check("redir req addr", 64'(req_a), 64'h300);
        wait_send("redir req", 32'h300, 3);

        // Reset during WAIT; the late response must be ignored
        lat = 3;
        step();
        rst_n = 1'b0;
        ready = 1'b0;
        #1;
        check("midrst req_valid", 64'(req_v), 64'd0);
        check("midrst send", 64'(send), 64'd0);
        check("midrst data", 64'(data), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("postrst req_valid", 64'(req_v), 64'd1);
        check("postrst addr", 64'(req_a), 64'd0);
        check("postrst send", 64'(send), 64'd0);
        step();
        check("late resp present", 64'(resp_v), 64'd1);
        check("late resp req_valid", 64'(req_v), 64'd1);
        ready = 1'b1;
        lat   = 1;
        wait_send("after reset", 32'h0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
